// File: rtl/plab5_mcore_dma_mem_responder.sv
// plab5_mcore_dma_mem_responder
//   The target end of the mem_req/mem_resp val/rdy interface, sitting in front of a
//   local word-addressed scratchpad. It takes one request at a time, waits a fixed
//   latency, then presents a tagged response and holds it until it is consumed.
//   Optional feature macro: PLAB5_MCORE_MEMRESP_DOMAIN_CHECK_EN. When it is defined,
//   insecure requesters (domain=0) are denied access to the upper half of the array.
module plab5_mcore_dma_mem_responder #(
   parameter  int p_opaque_nbits = 8,
   parameter  int p_addr_nbits   = 32,
   parameter  int p_data_nbits   = 32,
   parameter  int p_num_words    = 256,
   parameter  int p_latency      = 2,
   localparam int c_len_nbits    = $clog2(p_data_nbits/8),
   localparam int c_req_nbits    = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
   localparam int c_resp_nbits   = 3 + p_opaque_nbits + c_len_nbits
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req_val,
   output logic                    mem_req_rdy,
   input  logic [c_req_nbits-1:0]  mem_req_control,
   input  logic [p_data_nbits-1:0] mem_req_data,
   input  logic                    mem_req_domain,
   output logic                    mem_resp_val,
   input  logic                    mem_resp_rdy,
   output logic [c_resp_nbits-1:0] mem_resp_control,
   output logic [p_data_nbits-1:0] mem_resp_data,
   output logic                    mem_resp_domain,
   output logic                    mem_resp_err
);

   localparam int c_idx_nbits = $clog2(p_num_words);
   localparam int c_cnt_nbits = (p_latency > 1) ? $clog2(p_latency) : 1;
   localparam logic [c_cnt_nbits-1:0] c_cnt_init = c_cnt_nbits'(p_latency - 1);
   localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Request field split: {type, opaque, addr, len}, MSB first.
   logic [2:0]                req_type;
   logic [p_opaque_nbits-1:0] req_opaque;
   logic [p_addr_nbits-1:0]   req_addr;
   logic [c_len_nbits-1:0]    req_len;
   logic [c_idx_nbits-1:0]    req_idx;
   logic                      req_is_write;
   logic                      req_deny;
   logic                      req_xfer;

   assign {req_type, req_opaque, req_addr, req_len} = mem_req_control;

   // Full-word access only: the byte offset and upper address bits fall away, so
   // addresses wrap around the array.
   assign req_idx      = req_addr[c_idx_nbits+1:2];
   assign req_is_write = (req_type == 3'd1);

   // Only a slice of the address selects the word; fold the whole field here so the
   // ignored bits are visibly intentional.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr;

`ifdef PLAB5_MCORE_MEMRESP_DOMAIN_CHECK_EN
   // Upper half of the array is the secure region.
   assign req_deny = !mem_req_domain && req_idx[c_idx_nbits-1];
`else
   assign req_deny = 1'b0;
`endif

   state_t                    state_q,     state_d;
   logic [c_cnt_nbits-1:0]    cnt_q,       cnt_d;
   logic [c_resp_nbits-1:0]   resp_ctrl_q, resp_ctrl_d;
   logic [p_data_nbits-1:0]   resp_data_q, resp_data_d;
   logic                      resp_dom_q,  resp_dom_d;
   logic                      resp_err_q,  resp_err_d;
   logic                      mem_we;

   logic [p_data_nbits-1:0]   mem_q [p_num_words];

   // Handshake outputs are forced low while reset is held, even before the first edge.
   assign mem_req_rdy  = reset && (state_q == ST_IDLE);
   assign mem_resp_val = reset && (state_q == ST_RESP);
   assign req_xfer     = mem_req_val && mem_req_rdy;

   // Next-state and response-capture logic for the accept/wait/respond sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_ctrl_d = resp_ctrl_q;
      resp_data_d = resp_data_q;
      resp_dom_d  = resp_dom_q;
      resp_err_d  = resp_err_q;
      mem_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_xfer) begin
               resp_ctrl_d = {req_type, req_opaque, req_len};
               resp_dom_d  = mem_req_domain;
               resp_err_d  = req_deny;
               // Unknown types behave as reads; writes and denied accesses return 0.
               resp_data_d = (req_is_write || req_deny) ? '0 : mem_q[req_idx];
               mem_we      = req_is_write && !req_deny;
               cnt_d       = c_cnt_init;
               state_d     = (p_latency == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - c_cnt_one;
            if (cnt_q <= c_cnt_one) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_resp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         resp_ctrl_q <= '0;
         resp_data_q <= '0;
         resp_dom_q  <= 1'b0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         resp_ctrl_q <= resp_ctrl_d;
         resp_data_q <= resp_data_d;
         resp_dom_q  <= resp_dom_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Scratchpad write port; a write commits on its accept edge.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset on purpose: contents survive reset and a
      // storage array with reset would not map onto RAM.
      if (mem_we) begin
         mem_q[req_idx] <= mem_req_data;
      end
   end

   assign mem_resp_control = resp_ctrl_q;
   assign mem_resp_data    = resp_data_q;
   assign mem_resp_domain  = resp_dom_q;
   assign mem_resp_err     = resp_err_q;

endmodule

// File: tb/tb_plab5_mcore_dma_mem_responder.sv
// tb_plab5_mcore_dma_mem_responder
//   Directed bench for the memory responder. A transaction-level model (busy flag,
//   accept cycle, word array) predicts the outputs every cycle; the directed tasks
//   additionally pin hand-computed literal results.
module tb_plab5_mcore_dma_mem_responder;

   localparam int O    = 8;
   localparam int A    = 32;
   localparam int D    = 32;
   localparam int N    = 256;
   localparam int LAT  = 2;
   localparam int L    = 2;
   localparam int REQW = 3 + O + A + L;
   localparam int RSPW = 3 + O + L;

   logic            clk = 1'b0;
   logic            reset;
   logic            mem_req_val;
   logic            mem_req_rdy;
   logic [REQW-1:0] mem_req_control;
   logic [D-1:0]    mem_req_data;
   logic            mem_req_domain;
   logic            mem_resp_val;
   logic            mem_resp_rdy;
   logic [RSPW-1:0] mem_resp_control;
   logic [D-1:0]    mem_resp_data;
   logic            mem_resp_domain;
   logic            mem_resp_err;

   plab5_mcore_dma_mem_responder #(
      .p_opaque_nbits (O),
      .p_addr_nbits   (A),
      .p_data_nbits   (D),
      .p_num_words    (N),
      .p_latency      (LAT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_req_val      (mem_req_val),
      .mem_req_rdy      (mem_req_rdy),
      .mem_req_control  (mem_req_control),
      .mem_req_data     (mem_req_data),
      .mem_req_domain   (mem_req_domain),
      .mem_resp_val     (mem_resp_val),
      .mem_resp_rdy     (mem_resp_rdy),
      .mem_resp_control (mem_resp_control),
      .mem_resp_data    (mem_resp_data),
      .mem_resp_domain  (mem_resp_domain),
      .mem_resp_err     (mem_resp_err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc       = 0;   // posedges seen so far
   int          rst_edges = 0;   // consecutive posedges with reset low
   bit          busy      = 0;   // a request is accepted and its response not yet taken
   int          acc_edge  = 0;   // posedge number on which that request was accepted
   logic [31:0] model_mem [int];
   logic [RSPW-1:0] exp_ctrl;
   logic [D-1:0]    exp_data;
   logic            exp_dom;
   logic            exp_err;

   always @(posedge clk) begin
      cyc++;
      if (!reset) rst_edges++;
      else        rst_edges = 0;
   end

   // One compare process: inputs are stable at the falling edge, so the handshakes
   // that will happen on the next rising edge are known here as well.
   always @(negedge clk) begin
      logic [2:0]  m_type;
      logic [O-1:0] m_op;
      logic [A-1:0] m_addr;
      logic [L-1:0] m_len;
      int          m_idx;
      bit          m_deny;
      bit          exp_val;
      if (!reset) begin
         check("rst_req_rdy",  mem_req_rdy,  0);
         check("rst_resp_val", mem_resp_val, 0);
         if (rst_edges > 0) begin
            check("rst_resp_control", mem_resp_control, 0);
            check("rst_resp_data",    mem_resp_data,    0);
            check("rst_resp_domain",  mem_resp_domain,  0);
            check("rst_resp_err",     mem_resp_err,     0);
         end
         busy = 0;
      end else begin
         exp_val = busy && (cyc >= acc_edge + LAT - 1);
         check("req_rdy",  mem_req_rdy,  !busy);
         check("resp_val", mem_resp_val, exp_val);
         if (exp_val) begin
            check("resp_control", mem_resp_control, exp_ctrl);
            check("resp_data",    mem_resp_data,    exp_data);
            check("resp_domain",  mem_resp_domain,  exp_dom);
            check("resp_err",     mem_resp_err,     exp_err);
         end
         if (exp_val && mem_resp_rdy) begin
            busy = 0;
         end else if (!busy && mem_req_val) begin
            {m_type, m_op, m_addr, m_len} = mem_req_control;
            m_idx = int'((m_addr / 4) % N);
`ifdef PLAB5_MCORE_MEMRESP_DOMAIN_CHECK_EN
            m_deny = !mem_req_domain && (m_idx >= N/2);
`else
            m_deny = 0;
`endif
            exp_ctrl = {m_type, m_op, m_len};
            exp_dom  = mem_req_domain;
            exp_err  = m_deny;
            if (m_type == 3'd1 || m_deny) begin
               exp_data = '0;
            end else begin
               exp_data = model_mem.exists(m_idx) ? model_mem[m_idx] : 'x;
            end
            if (m_type == 3'd1 && !m_deny) model_mem[m_idx] = mem_req_data;
            busy     = 1;
            acc_edge = cyc + 1;
         end
      end
   end

   // ---------------- directed stimulus helpers ----------------
   // Present a request (called just after a rising edge) and return once accepted.
   task automatic issue(input logic [2:0] ty, input logic [O-1:0] op, input logic [A-1:0] addr,
                        input logic [L-1:0] len, input logic [D-1:0] data, input logic dom,
                        output int acc);
      bit got = 0;
      mem_req_val     = 1'b1;
      mem_req_control = {ty, op, addr, len};
      mem_req_data    = data;
      mem_req_domain  = dom;
      acc = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_req_rdy) begin
            got = 1;
            acc = cyc + 1;
            break;
         end
      end
      if (!got) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout: request never accepted within 50 cycles");
      end
      @(posedge clk);
      #1;
      mem_req_val = 1'b0;
   endtask

   // Wait for resp_val; returns at that falling edge with the sampled response and
   // the number of cycles since the accept edge.
   task automatic await_resp(output logic [RSPW-1:0] ctrl, output logic [D-1:0] data,
                             output logic err, output int lat);
      lat = 0;
      ctrl = 'x;
      data = 'x;
      err = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_resp_val) begin
            lat  = k;
            ctrl = mem_resp_control;
            data = mem_resp_data;
            err  = mem_resp_err;
            return;
         end
      end
      n_vec++;
      n_fail++;
      $display("FAIL resp_timeout: no response within 20 cycles");
   endtask

   // Full transaction with resp_rdy high: issue, wait, let the handshake edge pass.
   task automatic xact(input logic [2:0] ty, input logic [O-1:0] op, input logic [A-1:0] addr,
                       input logic [L-1:0] len, input logic [D-1:0] wdata, input logic dom,
                       output logic [RSPW-1:0] ctrl, output logic [D-1:0] data,
                       output logic err, output int lat, output int acc);
      issue(ty, op, addr, len, wdata, dom, acc);
      await_resp(ctrl, data, err, lat);
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [RSPW-1:0] ctrl;
      logic [D-1:0]    data;
      logic            err;
      int              lat, acc1, acc2;

      // 1: reset held 3 cycles with a request pending on the input.
      reset           = 1'b0;
      mem_req_val     = 1'b1;
      mem_req_control = {3'd1, 8'hAA, 32'h0000_0010, 2'd0};
      mem_req_data    = 32'h5555_5555;
      mem_req_domain  = 1'b1;
      mem_resp_rdy    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b1;
      mem_req_val = 1'b0;

      // 2: secure write then read of word 5.
      xact(3'd1, 8'h11, 32'h0000_0014, 2'd0, 32'hDEAD_BEEF, 1'b1, ctrl, data, err, lat, acc1);
      check("wr5_latency", lat, 2);
      check("wr5_ctrl", ctrl, {3'd1, 8'h11, 2'd0});
      check("wr5_data", data, 32'h0);
      check("wr5_err",  err,  0);
      xact(3'd0, 8'h22, 32'h0000_0014, 2'd3, 32'h0, 1'b1, ctrl, data, err, lat, acc1);
      check("rd5_latency", lat, 2);
      check("rd5_ctrl", ctrl, {3'd0, 8'h22, 2'd3});
      check("rd5_data", data, 32'hDEAD_BEEF);
      xact(3'd0, 8'h23, 32'h0000_0014, 2'd0, 32'h0, 1'b1, ctrl, data, err, lat, acc2);
      check("throughput_spacing", acc2 - acc1, 3);

      // 3: response back-pressure for 5 cycles.
      mem_resp_rdy = 1'b0;
      issue(3'd0, 8'h33, 32'h0000_0014, 2'd1, 32'h0, 1'b1, acc1);
      await_resp(ctrl, data, err, lat);
      check("bp_first_data", data, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_val",  mem_resp_val, 1);
         check("bp_hold_ctrl", mem_resp_control, {3'd0, 8'h33, 2'd1});
         check("bp_hold_data", mem_resp_data, 32'hDEAD_BEEF);
         check("bp_hold_rdy",  mem_req_rdy, 0);
         @(posedge clk);
         #1;
      end
      mem_resp_rdy = 1'b1;
      @(negedge clk);
      check("bp_release_val", mem_resp_val, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_after_rdy", mem_req_rdy, 1);
      check("bp_after_val", mem_resp_val, 0);
      @(posedge clk);
      #1;

      // 4: secure-region access from an insecure requester (word 200 = addr 0x320).
      xact(3'd1, 8'h40, 32'h0000_0320, 2'd0, 32'hCAFE_F00D, 1'b1, ctrl, data, err, lat, acc1);
      check("sec_wr_err", err, 0);
      xact(3'd1, 8'h41, 32'h0000_0320, 2'd0, 32'h1234_5678, 1'b0, ctrl, data, err, lat, acc1);
      check("insec_wr_data",    data, 32'h0);
      check("insec_wr_latency", lat, 2);
`ifdef PLAB5_MCORE_MEMRESP_DOMAIN_CHECK_EN
      check("insec_wr_err", err, 1);
      xact(3'd0, 8'h42, 32'h0000_0320, 2'd0, 32'h0, 1'b0, ctrl, data, err, lat, acc1);
      check("insec_rd_err",  err,  1);
      check("insec_rd_data", data, 32'h0);
      xact(3'd0, 8'h43, 32'h0000_0320, 2'd0, 32'h0, 1'b1, ctrl, data, err, lat, acc1);
      check("sec_rd_err",  err,  0);
      check("sec_rd_data", data, 32'hCAFE_F00D);
`else
      check("insec_wr_err", err, 0);
      xact(3'd0, 8'h43, 32'h0000_0320, 2'd0, 32'h0, 1'b1, ctrl, data, err, lat, acc1);
      check("sec_rd_err",  err,  0);
      check("sec_rd_data", data, 32'h1234_5678);
`endif
      // Insecure access to the lower half is always allowed.
      xact(3'd1, 8'h44, 32'h0000_0028, 2'd0, 32'h0F0F_0F0F, 1'b0, ctrl, data, err, lat, acc1);
      xact(3'd0, 8'h45, 32'h0000_0028, 2'd0, 32'h0, 1'b0, ctrl, data, err, lat, acc1);
      check("insec_low_data", data, 32'h0F0F_0F0F);
      check("insec_low_err",  err,  0);

      // 5: address wrap (0x404 and 0x004 both hit word 1), byte offset ignored.
      xact(3'd1, 8'h50, 32'h0000_0404, 2'd0, 32'hA5A5_0001, 1'b1, ctrl, data, err, lat, acc1);
      xact(3'd0, 8'h51, 32'h0000_0007, 2'd2, 32'h0, 1'b1, ctrl, data, err, lat, acc1);
      check("wrap_rd_data", data, 32'hA5A5_0001);
      check("wrap_rd_ctrl", ctrl, {3'd0, 8'h51, 2'd2});
      // Unknown type behaves as a read.
      xact(3'd5, 8'h52, 32'h0000_0004, 2'd0, 32'hFFFF_FFFF, 1'b1, ctrl, data, err, lat, acc1);
      check("unk_type_data", data, 32'hA5A5_0001);
      check("unk_type_err",  err,  0);
      check("unk_type_ctrl", ctrl, {3'd5, 8'h52, 2'd0});

      // 6: reset during the wait of a write; no response appears, data persists.
      issue(3'd1, 8'h60, 32'h0000_001C, 2'd0, 32'h0BAD_F00D, 1'b1, acc1);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_no_resp", mem_resp_val, 0);
      end
      @(posedge clk);
      #1;
      xact(3'd0, 8'h61, 32'h0000_001C, 2'd0, 32'h0, 1'b1, ctrl, data, err, lat, acc1);
      check("post_rst_rd_data", data, 32'h0BAD_F00D);
      check("post_rst_rd_lat",  lat,  2);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
